mult_result_collector: RTL and testbench



---
 rtl/mult_pkg.sv | 7 +
 rtl/sync_fifo_fwft.sv | 62 ++++++
 rtl/mult_result_collector.sv | 95 +++++++++
 tb/tb_mult_result_collector.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier result path.
package mult_pkg;
    localparam int PROD_W        = 16;
    localparam int ACC_W_DEFAULT = 24;

    typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with wrap-bit pointers; clr_i empties it synchronously.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    // Head is forced to zero when empty so the output is defined out of reset.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i & ~empty_o & ~clr_i;
    assign do_push = push_i & (~full_o | do_pop) & ~clr_i;

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/mult_result_collector.sv
// Captures one product per multiplier end_op rising edge into a FWFT FIFO.
// Define MULT_ACC_EN to add the acc_sum running-sum port and register.
module mult_result_collector
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  product_t               mul_result,
    input  logic                   mul_end_op,
    input  logic                   clr,
    output product_t               out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef MULT_ACC_EN
    output logic [ACC_W-1:0]       acc_sum,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    logic end_q;
    logic overflow_q, overflow_d;
    logic capture;
    logic pop;
    logic push_ok;
    logic fifo_full;
    logic fifo_empty;

    assign capture   = mul_end_op & ~end_q;
    assign pop       = out_valid & out_ready;
    assign push_ok   = capture & (~fifo_full | pop) & ~clr;
    assign out_valid = ~fifo_empty;
    assign overflow  = overflow_q;

    sync_fifo_fwft #(
        .WIDTH (PROD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (capture),
        .pop_i   (pop),
        .clr_i   (clr),
        .din_i   (mul_result),
        .dout_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (clr) begin
            overflow_d = 1'b0;
        end else if (capture && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // end_q tracks end_op even during clr so a held DONE never re-captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            end_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            end_q      <= mul_end_op;
            overflow_q <= overflow_d;
        end
    end

`ifdef MULT_ACC_EN
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (push_ok) begin
            acc_d = acc_q + ACC_W'(mul_result);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_sum = acc_q;
`else
    logic unused_push_ok;
    assign unused_push_ok = push_ok;
`endif
endmodule

// File: tb/tb_mult_result_collector.sv
// Scoreboard bench for mult_result_collector: a queue model predicts FIFO contents.
module tb_mult_result_collector;
    localparam int DEPTH = 4;
    localparam int ACC_W = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mul_result = '0;
    logic        mul_end_op = 1'b0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  count;
    logic        overflow;
`ifdef MULT_ACC_EN
    logic [ACC_W-1:0] acc_sum;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0]      sb_q[$];
    int               m_cnt  = 0;
    bit               m_ovf  = 0;
    bit               m_prev = 0;
    logic [ACC_W-1:0] m_acc  = '0;
    bit               m_cap, m_pop;

    bit          stall_prev = 0;
    logic [15:0] stall_data = '0;

    mult_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mul_result (mul_result),
        .mul_end_op (mul_end_op),
        .clr        (clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef MULT_ACC_EN
        .acc_sum    (acc_sum),
`endif
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a bounded queue of products, one capture per end_op rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  = 0;
            m_ovf  = 0;
            m_prev = 0;
            m_acc  = '0;
            sb_q.delete();
        end else begin
            m_cap  = mul_end_op && !m_prev;
            m_prev = mul_end_op;
            m_pop  = (m_cnt > 0) && out_ready;
            if (clr) begin
                m_cnt = 0;
                m_ovf = 0;
                m_acc = '0;
                sb_q.delete();
            end else begin
                if (m_pop) m_cnt--;
                if (m_cap) begin
                    if (m_cnt < DEPTH) begin
                        sb_q.push_back(mul_result);
                        m_cnt++;
                        m_acc = m_acc + ACC_W'(mul_result);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires the head on a transfer.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            check("count", 32'(count), 32'(m_cnt));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("out_valid", 32'(out_valid), 32'(m_cnt > 0));
`ifdef MULT_ACC_EN
            check("acc_sum", 32'(acc_sum), 32'(m_acc));
`endif
            if (stall_prev) check("stall_data", 32'(out_data), 32'(stall_data));
            if (m_cnt > 0 && sb_q.size() > 0) begin
                check("out_data", 32'(out_data), 32'(sb_q[0]));
                if (out_ready) void'(sb_q.pop_front());
            end
            stall_prev = out_valid && !out_ready && !clr;
            stall_data = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [15:0] val);
        mul_result = val;
        mul_end_op = 1'b1;
        tick();
        mul_end_op = 1'b0;
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && m_cnt > 0; i++) tick();
        out_ready = 1'b0;
        check("drain_done", 32'(out_valid), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick();

        // Held end_op yields exactly one capture
        mul_result = 16'h0C35;
        mul_end_op = 1'b1;
        tick();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h0C35);
        for (int i = 0; i < 4; i++) tick();
        check("t1_count", 32'(count), 32'd1);
        mul_end_op = 1'b0;
        tick();
        drain();

        // Overflow: fifth capture into a full FIFO is dropped
        for (int v = 1; v <= 5; v++) capture(16'(v));
        check("t2_count", 32'(count), 32'd4);
        check("t2_ovf", 32'(overflow), 32'd1);
        drain();
        check("t2_ovf_sticky", 32'(overflow), 32'd1);
        do_clr();
        tick();
        check("t2_clr_ovf", 32'(overflow), 32'd0);

        // Full FIFO: simultaneous push and pop
        for (int v = 11; v <= 14; v++) capture(16'(v));
        mul_result = 16'd9;
        mul_end_op = 1'b1;
        out_ready  = 1'b1;
        tick();
        check("t3_count", 32'(count), 32'd4);
        check("t3_ovf", 32'(overflow), 32'd0);
        check("t3_head", 32'(out_data), 32'd12);
        mul_end_op = 1'b0;
        out_ready  = 1'b0;
        tick();
        drain();

        // Toggling ready with spaced captures, exercising pointer wrap
        for (int i = 0; i < 24; i++) begin
            out_ready  = ~out_ready;
            mul_end_op = (i % 3 == 0);
            mul_result = 16'($urandom);
            tick();
        end
        mul_end_op = 1'b0;
        drain();

        // clr coinciding with a capture
        for (int v = 21; v <= 25; v++) capture(16'(v));
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("t5_pre_count", 32'(count), 32'd2);
        mul_result = 16'd77;
        mul_end_op = 1'b1;
        clr        = 1'b1;
        tick();
        clr        = 1'b0;
        check("t5_count", 32'(count), 32'd0);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        mul_end_op = 1'b0;
        tick();
        check("t5_discard", 32'(count), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            mul_end_op = ($urandom_range(0, 2) == 0);
            out_ready  = $urandom_range(0, 1);
            clr        = ($urandom_range(0, 63) == 0);
            mul_result = 16'($urandom);
            tick();
        end
        clr        = 1'b0;
        mul_end_op = 1'b0;
        tick();
        drain();

`ifdef MULT_ACC_EN
        do_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) capture(16'hFFFF);
        check("acc_300", 32'(acc_sum), 32'd2883284);
        for (int i = 0; i < 3; i++) capture(16'h1234);
        rst = 1'b1;
        #1;
        check("acc_rst", 32'(acc_sum), 32'd0);
        check("acc_rst_count", 32'(count), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
